// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO and char/go/ready sequencer feeding a UART transmitter
// Optional UART_TX_FEEDER_LEVEL_EN adds the level output and the flush input.
module uart_tx_feeder #(
    parameter int DEPTH_LOG2  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic [7:0]            char,
    output logic                  go,
    input  logic                  uart_ready,
`ifdef UART_TX_FEEDER_LEVEL_EN
    output logic [DEPTH_LOG2:0]   level,
    input  logic                  flush,
`endif
    output logic                  busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                  state;
    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     count;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    rdy_s;
    logic                    push;
    logic                    pop;
    logic                    flush_idle;

    // Sync flops reset low so a fresh ready level is required after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_ready};
        end
    end

    assign rdy_s = sync_q[SYNC_STAGES-1];

`ifdef UART_TX_FEEDER_LEVEL_EN
    assign flush_idle = flush & (state == IDLE);
    assign level      = count;
`else
    assign flush_idle = 1'b0;
`endif

    assign full  = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr_en & ~full & ~flush_idle;
    assign pop   = (state == IDLE) & ~empty & rdy_s & ~flush_idle;
    assign busy  = (state != IDLE) | ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // A write into a full FIFO is lost even if a pop frees a slot this cycle.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (flush_idle) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // go is only re-raised after rdy_s has been seen low then high again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            go    <= 1'b0;
            char  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        char  <= mem[rd_ptr];
                        go    <= 1'b1;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (!rdy_s) begin
                        go    <= 1'b0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (rdy_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    go    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
